// File: rtl/mcu51_bit_pkg.sv
// Shared definitions for the 8051 bit-instruction sequencer and its users.
//   - bit_op_e    : request opcode encodings (BIT_SETB .. BIT_TEST)
//   - bit_state_e : sequencer state encoding
//   - memory strobe polarities (CS_ACTIVE / RW_READ / RW_WRITE)
//   - small helpers that classify opcodes and compute the bit to write
package mcu51_bit_pkg;

    typedef enum logic [2:0] {
        BIT_SETB  = 3'b000,
        BIT_CLR   = 3'b001,
        BIT_CPL   = 3'b010,
        BIT_MOVBC = 3'b011,  // MOV bit <- C
        BIT_MOVCB = 3'b100,  // MOV C <- bit
        BIT_ANL   = 3'b101,  // ANL C,bit
        BIT_ORL   = 3'b110,  // ORL C,bit
        BIT_TEST  = 3'b111
    } bit_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        VREAD = 3'd4,
        VWAIT = 3'd5,
        DONE  = 3'd6
    } bit_state_e;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    // Ops that never need the old bit value go straight to WRITE.
    function automatic logic op_is_write_only(bit_op_e op);
        return (op == BIT_SETB) || (op == BIT_CLR) || (op == BIT_MOVBC);
    endfunction

    // Ops whose result must be written back to the carry flag.
    function automatic logic op_updates_c(bit_op_e op);
        return (op == BIT_MOVCB) || (op == BIT_ANL) || (op == BIT_ORL);
    endfunction

    // Bit value driven onto mem_din during WRITE.
    function automatic logic write_value(bit_op_e op, logic rd, logic c);
        logic v;
        case (op)
            BIT_SETB:  v = 1'b1;
            BIT_CLR:   v = 1'b0;
            BIT_CPL:   v = ~rd;
            BIT_MOVBC: v = c;
            default:   v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bit_op_ctrl_if.sv
// Request/response handshake between instruction decode and bit_op_ctrl.
//   master : decode side   (drives req_valid/req_op/req_addr/c_in)
//   slave  : sequencer side (drives req_ready/done/c_out/c_we/rsp_bit/rsp_err)
interface bit_op_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [ADDRWIDTH-1:0] req_addr;
    logic                 c_in;
    logic                 done;
    logic                 c_out;
    logic                 c_we;
    logic                 rsp_bit;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_addr, c_in,
        input  req_ready, done, c_out, c_we, rsp_bit, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, c_in,
        output req_ready, done, c_out, c_we, rsp_bit, rsp_err
    );
endinterface

// File: rtl/bit_op_ctrl.sv
// bit_op_ctrl: sequences one 8051 bit instruction into chip-select / read-write
// cycles on the bit-addressable memory, doing read-modify-write when needed and
// producing the carry result. One op in flight; req_ready only in IDLE.
//
// Ports:
//   clk, rst        : clock shared with the bit memory; sync active-high reset
//   req (slave)     : op request + done/c_out/c_we/rsp_bit/rsp_err response
//   mem_cs/mem_rw   : memory strobes (cs active low, rw 1=read 0=write)
//   mem_addr/mem_din: memory address and write data
//   mem_dout        : memory read data, registered one edge after the read
//
// Optional build macro BITOP_READBACK_EN: after every WRITE the bit is read
// back (VREAD/VWAIT) and rsp_err flags a mismatch. Without it rsp_err is 0.
module bit_op_ctrl
    import mcu51_bit_pkg::*;
#(
    parameter int ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_op_ctrl_if.slave         req,
    output logic                 mem_cs,
    output logic                 mem_rw,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 mem_din,
    input  logic                 mem_dout
);

    bit_state_e           state_q, state_d;
    bit_op_e              op_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic                 c_q;
    logic                 rd_q;
    logic                 c_out_q;
    logic                 rsp_bit_q;
    logic                 wr_val;
    logic                 accept;

    assign accept = (state_q == IDLE) && req.req_valid;
    assign wr_val = write_value(op_q, rd_q, c_q);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req.req_valid)
                       state_d = op_is_write_only(bit_op_e'(req.req_op)) ? WRITE : READ;
            READ:  state_d = WAIT;
            WAIT:  state_d = (op_q == BIT_CPL) ? WRITE : DONE;
`ifdef BITOP_READBACK_EN
            WRITE: state_d = VREAD;
            VREAD: state_d = VWAIT;
            VWAIT: state_d = DONE;
`else
            WRITE: state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= BIT_SETB;
            addr_q    <= '0;
            c_q       <= 1'b0;
            rd_q      <= 1'b0;
            c_out_q   <= 1'b0;
            rsp_bit_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= bit_op_e'(req.req_op);
                addr_q <= req.req_addr;
                c_q    <= req.c_in;
            end
            // mem_dout is only meaningful here; it floats everywhere else.
            if (state_q == WAIT) begin
                rd_q      <= mem_dout;
                rsp_bit_q <= mem_dout;
                case (op_q)
                    BIT_MOVCB: c_out_q <= mem_dout;
                    BIT_ANL:   c_out_q <= c_q & mem_dout;
                    BIT_ORL:   c_out_q <= c_q | mem_dout;
                    default:   c_out_q <= c_out_q;
                endcase
            end
        end
    end

`ifdef BITOP_READBACK_EN
    logic rsp_err_q;

    // Cleared on accept so read-only ops never report a stale error.
    always_ff @(posedge clk) begin
        if (rst)                     rsp_err_q <= 1'b0;
        else if (accept)             rsp_err_q <= 1'b0;
        else if (state_q == VWAIT)   rsp_err_q <= (mem_dout != wr_val);
    end

    assign req.rsp_err = rsp_err_q;
`else
    assign req.rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------ outputs
    // Memory strobes decode straight from the state register; the address
    // simply follows addr_q so it is stable across every memory cycle.
    always_comb begin
        mem_cs  = CS_IDLE;
        mem_rw  = RW_READ;
        mem_din = 1'b0;
        case (state_q)
            READ, VREAD: mem_cs = CS_ACTIVE;
            WRITE: begin
                mem_cs  = CS_ACTIVE;
                mem_rw  = RW_WRITE;
                mem_din = wr_val;
            end
            default: ;
        endcase
    end

    assign mem_addr      = addr_q;
    assign req.req_ready = (state_q == IDLE) && !rst;
    assign req.done      = (state_q == DONE);
    assign req.c_we      = (state_q == DONE) && op_updates_c(op_q);
    assign req.c_out     = c_out_q;
    assign req.rsp_bit   = rsp_bit_q;

endmodule

// File: tb/tb_bit_op_ctrl.sv
// Self-checking bench for bit_op_ctrl with a behavioural model of the bit
// memory (dout registered one edge after a read, z otherwise).
module tb_bit_op_ctrl;
    import mcu51_bit_pkg::*;

    localparam int AW = 3;
`ifdef BITOP_READBACK_EN
    localparam int RB_EXTRA = 2;
`else
    localparam int RB_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_cs, mem_rw, mem_din;
    logic [AW-1:0] mem_addr;
    logic          mem_dout;
    logic          mem_clr;
    logic          corrupt;
    logic          mem_arr [8];

    int checks   = 0;
    int failures = 0;

    // Reference state: what the bit memory should hold.
    logic model_mem [8];

    always #5 clk = ~clk;

    bit_op_ctrl_if #(.ADDRWIDTH(AW)) bif ();

    bit_op_ctrl #(.ADDRWIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (bif),
        .mem_cs   (mem_cs),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Bit memory model
    always @(posedge clk) begin
        mem_dout <= 1'bz;
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) mem_arr[i] <= 1'b0;
        end else if (mem_cs == 1'b0) begin
            if (mem_rw == 1'b0) mem_arr[mem_addr] <= mem_din;
            else                mem_dout <= corrupt ? 1'b0 : mem_arr[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one op from IDLE and check it against the model.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [2:0] addr,
                         input logic cin, input logic exp_err);
        logic cur, nxt, rb, cres, reads, writes, cwe;
        int   lat, cyc, wr_seen;
        logic wr_din;
        cur    = model_mem[addr];
        nxt    = cur;
        rb     = cur;
        cres   = 1'b0;
        reads  = 1'b1;
        writes = 1'b0;
        cwe    = 1'b0;
        case (op)
            3'd0: begin nxt = 1'b1;  writes = 1; reads = 0; end
            3'd1: begin nxt = 1'b0;  writes = 1; reads = 0; end
            3'd2: begin nxt = ~cur;  writes = 1; end
            3'd3: begin nxt = cin;   writes = 1; reads = 0; end
            3'd4: begin cres = cur;        cwe = 1; end
            3'd5: begin cres = cin & cur;  cwe = 1; end
            3'd6: begin cres = cin | cur;  cwe = 1; end
            default: ;
        endcase
        // Cycles from accept to done: 1 per memory access cycle beyond accept,
        // read adds a wait cycle, readback adds another read+wait.
        lat = 1 + (reads ? 2 : 0) + (writes ? 1 + RB_EXTRA : 0);

        chk({tag, "/ready"}, bif.req_ready, 1);
        bif.req_valid = 1'b1;
        bif.req_op    = op;
        bif.req_addr  = addr;
        bif.c_in      = cin;
        step();
        bif.req_valid = 1'b0;
        bif.c_in      = $urandom_range(0, 1);  // c_in must be latched, not live
        cyc     = 1;
        wr_seen = 0;
        wr_din  = 1'b0;
        while (bif.done !== 1'b1 && cyc < 20) begin
            if (mem_cs === 1'b0 && mem_rw === 1'b0) begin
                wr_seen++;
                wr_din = mem_din;
            end
            step();
            cyc++;
        end
        chk({tag, "/done"}, bif.done, 1);
        chk({tag, "/lat"}, cyc, lat);
        chk({tag, "/c_we"}, bif.c_we, cwe);
        if (cwe)   chk({tag, "/c_out"}, bif.c_out, cres);
        if (reads) chk({tag, "/rsp_bit"}, bif.rsp_bit, rb);
        chk({tag, "/rsp_err"}, bif.rsp_err, exp_err);
        chk({tag, "/writes"}, wr_seen, writes ? 1 : 0);
        if (writes) chk({tag, "/din"}, wr_din, nxt);
        model_mem[addr] = nxt;
        step();
        chk({tag, "/done_pulse"}, bif.done, 0);
        chk({tag, "/mem"}, mem_arr[addr], model_mem[addr]);
    endtask

    initial begin
        int accepts, dones;
        logic orig7;

        rst           = 1'b1;
        mem_clr       = 1'b1;
        corrupt       = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_op    = 3'd0;
        bif.req_addr  = '0;
        bif.c_in      = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst/ready",   bif.req_ready, 0);
        chk("rst/done",    bif.done, 0);
        chk("rst/c_we",    bif.c_we, 0);
        chk("rst/c_out",   bif.c_out, 0);
        chk("rst/rsp_bit", bif.rsp_bit, 0);
        chk("rst/rsp_err", bif.rsp_err, 0);
        chk("rst/cs",      mem_cs, 1);
        chk("rst/rw",      mem_rw, 1);
        chk("rst/addr",    mem_addr, 0);
        chk("rst/din",     mem_din, 0);
        rst     = 1'b0;
        mem_clr = 1'b0;
        #1;
        chk("post_rst/ready", bif.req_ready, 1);
        step();

        // Directed sequence
        do_op("setb5",  3'd0, 3'd5, 1'b0, 1'b0);
        do_op("test5",  3'd7, 3'd5, 1'b0, 1'b0);
        do_op("clr5",   3'd1, 3'd5, 1'b1, 1'b0);
        do_op("cpl5",   3'd2, 3'd5, 1'b0, 1'b0);
        do_op("test5b", 3'd7, 3'd5, 1'b0, 1'b0);
        do_op("movbc2", 3'd3, 3'd2, 1'b1, 1'b0);
        do_op("orl2",   3'd6, 3'd2, 1'b0, 1'b0);
        do_op("clr3",   3'd1, 3'd3, 1'b0, 1'b0);
        do_op("anl3",   3'd5, 3'd3, 1'b1, 1'b0);
        do_op("movcb2", 3'd4, 3'd2, 1'b0, 1'b0);

        // req_valid held for 10 cycles: only IDLE cycles accept
        orig7         = model_mem[7];
        accepts       = 0;
        dones         = 0;
        bif.req_valid = 1'b1;
        bif.req_op    = 3'd2;
        bif.req_addr  = 3'd7;
        for (int i = 0; i < 10; i++) begin
            if (bif.req_ready === 1'b1) accepts++;
            if (bif.done === 1'b1) dones++;
            step();
        end
        bif.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bif.done === 1'b1) dones++;
            step();
        end
        chk("hold/accepts", accepts, 2);
        chk("hold/dones",   dones, 2);
        chk("hold/bit7",    mem_arr[7], orig7);
        chk("hold/ready",   bif.req_ready, 1);

        // Reset during WAIT of a CPL: no done, no write
        bif.req_valid = 1'b1;
        bif.req_op    = 3'd2;
        bif.req_addr  = 3'd4;
        step();                 // READ
        bif.req_valid = 1'b0;
        step();                 // WAIT
        chk("rstw/wait_cs", mem_cs, 1);
        rst = 1'b1;
        step();
        chk("rstw/state", dut.state_q, IDLE);
        chk("rstw/cs",    mem_cs, 1);
        chk("rstw/done",  bif.done, 0);
        chk("rstw/ready", bif.req_ready, 0);
        chk("rstw/c_out", bif.c_out, 0);
        chk("rstw/addr",  mem_addr, 0);
        rst = 1'b0;
        #1;
        chk("rstw/ready_after", bif.req_ready, 1);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (bif.done === 1'b1) dones++;
            step();
        end
        chk("rstw/no_done", dones, 0);
        chk("rstw/bit4",    mem_arr[4], model_mem[4]);

`ifdef BITOP_READBACK_EN
        do_op("rb_setb1", 3'd0, 3'd1, 1'b0, 1'b0);
        corrupt = 1'b1;
        do_op("rb_err1",  3'd0, 3'd1, 1'b0, 1'b1);
        corrupt = 1'b0;
        do_op("rb_test1", 3'd7, 3'd1, 1'b0, 1'b0);
`endif

        // Random ops against the model
        for (int n = 0; n < 80; n++) begin
            do_op("rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
